// File: rtl/window3x3_stream.sv
// 3x3 sliding-window builder for a raster pixel stream: two line buffers plus a
// register window, flagging only full interior neighbourhoods as valid.
module window3x3_stream #(
    parameter int DATA_W = 24,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic [DATA_W-1:0] x00,
    output logic [DATA_W-1:0] x01,
    output logic [DATA_W-1:0] x02,
    output logic [DATA_W-1:0] x10,
    output logic [DATA_W-1:0] x11,
    output logic [DATA_W-1:0] x12,
    output logic [DATA_W-1:0] x20,
    output logic [DATA_W-1:0] x21,
    output logic [DATA_W-1:0] x22,
    output logic              out_valid,
    output logic [COL_W-1:0]  out_col,
    output logic [ROW_W-1:0]  out_row
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_out_col;
    logic [ROW_W-1:0] r_out_row;
    logic             r_valid;
    // r_win[R][C]: R=0 is the oldest line, C=0 the oldest column
    logic [2:0][2:0][DATA_W-1:0] r_win;

    logic [DATA_W-1:0] r_lb0 [WIDTH];
    logic [DATA_W-1:0] r_lb1 [WIDTH];

    logic              w_accept;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;

    // in_sof pins the accepted pixel to (0,0) regardless of the counters
    assign w_accept = in_valid && reset_n;
    assign w_col    = in_sof ? '0 : r_col;
    assign w_row    = in_sof ? '0 : r_row;
    assign w_lb0_rd = r_lb0[w_col];
    assign w_lb1_rd = r_lb1[w_col];

    // Line buffers carry no reset; stale contents are masked by the row/col guard
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_col] <= w_lb0_rd;
            r_lb0[w_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_out_col <= '0;
            r_out_row <= '0;
            r_valid   <= 1'b0;
            r_win     <= '0;
        end else begin
            r_valid <= in_valid && (w_col >= COL_W'(2)) && (w_row >= ROW_W'(2));
            if (in_valid) begin
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
                r_out_col <= w_col - 1'b1;
                r_out_row <= w_row - 1'b1;
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb1_rd;
                r_win[1][2] <= w_lb0_rd;
                r_win[2][2] <= in_pixel;
            end
        end
    end

    assign x00       = r_win[0][0];
    assign x01       = r_win[0][1];
    assign x02       = r_win[0][2];
    assign x10       = r_win[1][0];
    assign x11       = r_win[1][1];
    assign x12       = r_win[1][2];
    assign x20       = r_win[2][0];
    assign x21       = r_win[2][1];
    assign x22       = r_win[2][2];
    assign out_valid = r_valid;
    assign out_col   = r_out_col;
    assign out_row   = r_out_row;

endmodule
